caravel_boot_core: RTL and testbench



---
 rtl/caravel_boot_core.sv | 219 +++++++++++++++++++++
 tb/tb_caravel_boot_core.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/caravel_boot_core.sv
// caravel_boot_core: boots from SPI flash (0x03 read), runs a byte-coded program on check bits / UART TX (FLASH_WAKEUP_EN adds 0xAB wakeup).
// Latency: 8 power-good cycles, 64-clock read command, 16 clocks per byte plus 1 decode clock, 10*BAUD_DIV clocks per UART byte.
// Backpressure: none external; the SPI clock parks low with csb held while a UART byte drains.
module caravel_boot_core #(
  parameter int          BAUD_DIV   = 16,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter int          MAX_BYTES  = 4096
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        vccd,
  input  logic        vddio,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1,
  output logic [37:0] mprj_io,
  output logic        gpio
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAKE, S_GAP, S_CMD, S_ADDR, S_FETCH, S_EXEC, S_UART, S_HALT
  } state_t;

  localparam logic [31:0] RD_WORD   = {8'h03, FLASH_BASE};
  localparam logic [31:0] MAX_CNT   = 32'(MAX_BYTES);
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
`ifdef FLASH_WAKEUP_EN
  localparam state_t      FIRST_STATE = S_WAKE;
  localparam logic [31:0] FIRST_WORD  = {8'hAB, 24'h000000};
`else
  localparam state_t      FIRST_STATE = S_CMD;
  localparam logic [31:0] FIRST_WORD  = RD_WORD;
`endif

  state_t      state, next_state;
  logic        pg;
  logic [2:0]  idle_cnt;
  logic [1:0]  gap_cnt;
  logic [4:0]  bit_cnt;
  logic [31:0] tx_sr;
  logic [7:0]  rx_sr;
  logic [31:0] byte_cnt;
  logic [1:0]  opnd;
  logic [7:0]  op;
  logic [7:0]  hi;
  logic [15:0] checkbits;
  logic [8:0]  uart_sr;
  logic [15:0] baud_cnt;
  logic [3:0]  ubit;
  logic        tx;
  logic        csb_q, sclk_q, mosi_q, gpio_q;

  logic shifting, spi_fall, uart_bit_end;
  assign shifting     = state inside {S_WAKE, S_CMD, S_ADDR, S_FETCH};
  assign spi_fall     = shifting && sclk_q;
  assign uart_bit_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) pg <= 1'b0;
    else         pg <= vccd & vddio;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state <= S_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (idle_cnt == 3'd7) next_state = FIRST_STATE;
      S_WAKE:  if (spi_fall && bit_cnt == 5'd7) next_state = S_GAP;
      S_GAP:   if (gap_cnt == 2'd3) next_state = S_CMD;
      S_CMD:   if (spi_fall && bit_cnt == 5'd7) next_state = S_ADDR;
      S_ADDR:  if (spi_fall && bit_cnt == 5'd31) next_state = S_FETCH;
      S_FETCH: if (spi_fall && bit_cnt == 5'd7) next_state = S_EXEC;
      S_EXEC: begin
        // Opcodes whose operands would run past the byte budget halt unexecuted.
        if (opnd == 2'd0) begin
          case (rx_sr)
            8'h00:   next_state = S_HALT;
            8'h01:   next_state = (byte_cnt + 32'd2 > MAX_CNT) ? S_HALT : S_FETCH;
            8'h02:   next_state = (byte_cnt + 32'd1 > MAX_CNT) ? S_HALT : S_FETCH;
            default: next_state = (byte_cnt >= MAX_CNT) ? S_HALT : S_FETCH;
          endcase
        end else if (opnd == 2'd1 && op == 8'h02) begin
          next_state = S_UART;
        end else if (opnd == 2'd1) begin
          next_state = S_FETCH;
        end else begin
          next_state = (byte_cnt >= MAX_CNT) ? S_HALT : S_FETCH;
        end
      end
      S_UART:  if (uart_bit_end && ubit == 4'd9)
                 next_state = (byte_cnt >= MAX_CNT) ? S_HALT : S_FETCH;
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
    if (!pg) next_state = S_IDLE;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      idle_cnt <= '0; gap_cnt <= '0; bit_cnt <= '0; tx_sr <= '0; rx_sr <= '0;
      byte_cnt <= '0; opnd <= '0; op <= '0; hi <= '0; checkbits <= '0;
      uart_sr <= '1; baud_cnt <= '0; ubit <= '0; tx <= 1'b1;
      csb_q <= 1'b1; sclk_q <= 1'b0; mosi_q <= 1'b0; gpio_q <= 1'b0;
    end else if (!pg) begin
      // Power loss aborts like reset but keeps the last check bits visible.
      idle_cnt <= '0; gap_cnt <= '0; bit_cnt <= '0; tx_sr <= '0; rx_sr <= '0;
      byte_cnt <= '0; opnd <= '0; op <= '0; hi <= '0;
      uart_sr <= '1; baud_cnt <= '0; ubit <= '0; tx <= 1'b1;
      csb_q <= 1'b1; sclk_q <= 1'b0; mosi_q <= 1'b0; gpio_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (idle_cnt == 3'd7) begin
            idle_cnt <= '0;
            csb_q    <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= FIRST_WORD[31];
            tx_sr    <= {FIRST_WORD[30:0], 1'b0};
            bit_cnt  <= '0;
            byte_cnt <= '0;
            opnd     <= '0;
          end else begin
            idle_cnt <= idle_cnt + 3'd1;
          end
        end
        S_WAKE, S_CMD, S_ADDR, S_FETCH: begin
          if (!sclk_q) begin
            sclk_q <= 1'b1;
          end else begin
            // Falling SPI edge: capture MISO and present the next MOSI bit together.
            sclk_q  <= 1'b0;
            rx_sr   <= {rx_sr[6:0], flash_io1};
            mosi_q  <= tx_sr[31];
            tx_sr   <= {tx_sr[30:0], 1'b0};
            bit_cnt <= bit_cnt + 5'd1;
            if (state == S_WAKE && bit_cnt == 5'd7) begin
              csb_q   <= 1'b1;
              mosi_q  <= 1'b0;
              gap_cnt <= '0;
            end
            if (state == S_ADDR && bit_cnt == 5'd31) begin
              bit_cnt <= '0;
              mosi_q  <= 1'b0;
            end
            if (state == S_FETCH && bit_cnt == 5'd7) begin
              bit_cnt  <= '0;
              byte_cnt <= byte_cnt + 32'd1;
            end
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + 2'd1;
          if (gap_cnt == 2'd3) begin
            csb_q   <= 1'b0;
            mosi_q  <= RD_WORD[31];
            tx_sr   <= {RD_WORD[30:0], 1'b0};
            bit_cnt <= '0;
          end
        end
        S_EXEC: begin
          case (opnd)
            2'd0: begin
              op <= rx_sr;
              if (rx_sr == 8'h01 || rx_sr == 8'h02) opnd <= 2'd1;
            end
            2'd1: begin
              if (op == 8'h01) begin
                hi   <= rx_sr;
                opnd <= 2'd2;
              end else begin
                opnd     <= 2'd0;
                tx       <= 1'b0;
                uart_sr  <= {1'b1, rx_sr};
                baud_cnt <= '0;
                ubit     <= '0;
              end
            end
            2'd2: begin
              checkbits <= {hi, rx_sr};
              opnd      <= 2'd0;
            end
            default: opnd <= 2'd0;
          endcase
        end
        S_UART: begin
          if (uart_bit_end) begin
            baud_cnt <= '0;
            if (ubit != 4'd9) begin
              tx      <= uart_sr[0];
              uart_sr <= {1'b1, uart_sr[8:1]};
              ubit    <= ubit + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: ;
      endcase
      if (next_state == S_HALT) begin
        csb_q  <= 1'b1;
        sclk_q <= 1'b0;
        mosi_q <= 1'b0;
        gpio_q <= 1'b1;
      end
    end
  end

  assign flash_csb = csb_q;
  assign flash_clk = sclk_q;
  assign flash_io0 = mosi_q;
  assign gpio      = gpio_q;
  assign mprj_io   = {6'b0, checkbits, 9'b0, tx, 6'b0};

endmodule

// File: tb/tb_caravel_boot_core.sv
// Directed bench for caravel_boot_core: behavioural SPI flash, UART line monitor, per-scenario tasks.
module tb_caravel_boot_core;
  localparam int BD   = 16;
  localparam int MAXB = 8;

  logic        clock = 1'b0;
  logic        resetb = 1'b1;
  logic        vccd = 1'b0;
  logic        vddio = 1'b0;
  logic        flash_csb, flash_clk, flash_io0;
  logic        flash_io1 = 1'b0;
  logic [37:0] mprj_io;
  logic        gpio;

  int n_checks = 0;
  int n_fail   = 0;

  caravel_boot_core #(.BAUD_DIV(BD), .FLASH_BASE(24'h000000), .MAX_BYTES(MAXB)) dut (
    .clock(clock), .resetb(resetb), .vccd(vccd), .vddio(vddio),
    .flash_csb(flash_csb), .flash_clk(flash_clk), .flash_io0(flash_io0),
    .flash_io1(flash_io1), .mprj_io(mprj_io), .gpio(gpio)
  );

  always #5 clock = ~clock;

  // Flash model: MOSI sampled on rising flash_clk, data shifted out on falling flash_clk.
  logic [7:0]  mem [0:31];
  int          fl_rise = 0, fl_txn = 0, fl_total = 0;
  logic [31:0] fl_cmd = '0, fl_word = '0;
  logic [7:0]  fl_first [$];
  int          csb_fall_q [$], csb_rise_q [$];
  int          cyc = 0;

  always @(negedge flash_csb or posedge flash_clk) begin
    if (!flash_clk) begin
      fl_rise = 0;
      fl_txn++;
      csb_fall_q.push_back(cyc);
    end else if (!flash_csb) begin
      fl_cmd = {fl_cmd[30:0], flash_io0};
      fl_rise++;
      fl_total++;
      if (fl_rise == 8)  fl_first.push_back(fl_cmd[7:0]);
      if (fl_rise == 32) fl_word = fl_cmd;
    end
  end

  always @(negedge flash_clk) begin
    int k;
    if (!flash_csb && fl_rise >= 32) begin
      k = fl_rise - 32;
      flash_io1 = mem[(k / 8) % 32][7 - (k % 8)];
    end
  end

  always @(posedge flash_csb) csb_rise_q.push_back(cyc);

  // UART monitor plus a log of every TX line transition (in negedge-clock counts).
  logic       last_tx = 1'b1;
  int         edge_q [$];
  logic [7:0] uart_q [$];
  int         tog_q [$];
  int         frame_err = 0;
  logic       u_busy = 1'b0;
  int         u_cnt = 0, u_tot0 = 0;
  logic [7:0] u_dat = '0;

  always @(negedge clock) begin
    cyc++;
    if (mprj_io[6] !== last_tx) edge_q.push_back(cyc);
    if (!resetb) begin
      u_busy = 1'b0;
    end else if (u_busy) begin
      u_cnt++;
      if (u_cnt % BD == BD / 2) begin
        if (u_cnt / BD == 0) begin
          if (mprj_io[6] !== 1'b0) frame_err++;
        end else if (u_cnt / BD <= 8) begin
          u_dat[u_cnt / BD - 1] = mprj_io[6];
        end else begin
          if (mprj_io[6] !== 1'b1) frame_err++;
          uart_q.push_back(u_dat);
          tog_q.push_back(fl_total - u_tot0);
          u_busy = 1'b0;
        end
      end
    end else if (mprj_io[6] === 1'b0 && last_tx === 1'b1) begin
      u_busy = 1'b1;
      u_cnt  = 0;
      u_tot0 = fl_total;
    end
    last_tx = mprj_io[6];
  end

  task automatic load(input logic [63:0] p, input int n, input logic [7:0] fill);
    for (int i = 0; i < 32; i++) mem[i] = (i < n) ? p[63 - 8 * i -: 8] : fill;
  endtask

  task automatic start_boot(input logic [63:0] p, input int n, input logic [7:0] fill);
    resetb = 1'b0;
    vccd = 1'b1;
    vddio = 1'b1;
    load(p, n, fill);
    repeat (3) @(negedge clock);
    resetb = 1'b1;
  endtask

  task automatic wait_halt(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clock);
      if (gpio === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    int n;
    load(64'h0, 0, 8'h00);
    #2 resetb = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++; if (flash_csb !== 1'b1) begin n_fail++; $display("FAIL reset_csb got %b want 1", flash_csb); end
    n_checks++; if (flash_clk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got %b want 0", flash_clk); end
    n_checks++; if (flash_io0 !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got %b want 0", flash_io0); end
    n_checks++; if (gpio !== 1'b0) begin n_fail++; $display("FAIL reset_gpio got %b want 0", gpio); end
    n_checks++; if (mprj_io !== 38'h0000000040) begin n_fail++; $display("FAIL reset_mprj got %h want 0000000040", mprj_io); end
    resetb = 1'b1;
    repeat (20) @(negedge clock);
    n_checks++; if (flash_csb !== 1'b1) begin n_fail++; $display("FAIL rails_off_csb got %b want 1", flash_csb); end
    vccd = 1'b1;
    repeat (20) @(negedge clock);
    n_checks++; if (flash_csb !== 1'b1) begin n_fail++; $display("FAIL one_rail_csb got %b want 1", flash_csb); end
    vddio = 1'b1;
    n = 0;
    for (int i = 0; i < 40 && flash_csb === 1'b1; i++) begin
      @(negedge clock);
      if (flash_csb === 1'b1) n++;
    end
    n_checks++; if (n < 8 || n > 12) begin n_fail++; $display("FAIL power_settle got %0d cycles want 8..12", n); end
  endtask

  task automatic test_read_framing;
    logic ok;
    int t0, f0, r0;
    t0 = fl_txn; f0 = fl_first.size(); r0 = csb_rise_q.size();
    start_boot(64'h01ABCD00_00000000, 4, 8'h00);
    wait_halt(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL read_halt got %b want 1", ok); end
    n_checks++; if (fl_word !== 32'h03000000) begin n_fail++; $display("FAIL read_cmd got %h want 03000000", fl_word); end
    n_checks++; if (fl_rise !== 64) begin n_fail++; $display("FAIL read_rises got %0d want 64", fl_rise); end
    n_checks++; if (mprj_io !== {6'b0, 16'hABCD, 9'b0, 1'b1, 6'b0}) begin n_fail++; $display("FAIL read_mprj got %h want %h", mprj_io, {6'b0, 16'hABCD, 9'b0, 1'b1, 6'b0}); end
    n_checks++; if ({flash_csb, flash_clk} !== 2'b10) begin n_fail++; $display("FAIL read_halt_bus got %b want 10", {flash_csb, flash_clk}); end
`ifdef FLASH_WAKEUP_EN
    n_checks++; if (fl_txn - t0 !== 2) begin n_fail++; $display("FAIL wake_txns got %0d want 2", fl_txn - t0); end
    n_checks++; if (fl_first.size() < f0 + 2 || fl_first[f0] !== 8'hAB || fl_first[f0 + 1] !== 8'h03) begin n_fail++; $display("FAIL wake_bytes got %0d entries want AB then 03", fl_first.size() - f0); end
    n_checks++; if (csb_rise_q.size() <= r0 || csb_fall_q[csb_fall_q.size() - 1] - csb_rise_q[r0] !== 4) begin n_fail++; $display("FAIL wake_gap got rises %0d want gap 4", csb_rise_q.size() - r0); end
`else
    n_checks++; if (fl_txn - t0 !== 1) begin n_fail++; $display("FAIL read_txns got %0d want 1 (r0 %0d)", fl_txn - t0, r0); end
    n_checks++; if (fl_first.size() <= f0 || fl_first[f0] !== 8'h03) begin n_fail++; $display("FAIL first_byte got %0d entries want 03 first", fl_first.size() - f0); end
`endif
  endtask

  task automatic test_opcode_decode;
    logic ok;
    start_boot(64'h7F011234_00000000, 5, 8'h00);
    wait_halt(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL dec_halt got %b want 1", ok); end
    n_checks++; if (mprj_io[31:16] !== 16'h1234) begin n_fail++; $display("FAIL dec_check got %h want 1234", mprj_io[31:16]); end
    n_checks++; if (fl_rise !== 72) begin n_fail++; $display("FAIL dec_rises got %0d want 72", fl_rise); end
  endtask

  task automatic test_uart;
    logic ok;
    int e0, u0, fe0, bad;
    e0 = edge_q.size(); u0 = uart_q.size(); fe0 = frame_err;
    start_boot(64'h025502A3_00000000, 5, 8'h00);
    wait_halt(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL uart_halt got %b want 1", ok); end
    n_checks++; if (uart_q.size() - u0 !== 2) begin n_fail++; $display("FAIL uart_count got %0d want 2", uart_q.size() - u0); end
    n_checks++; if (uart_q.size() < u0 + 2 || uart_q[u0] !== 8'h55 || uart_q[u0 + 1] !== 8'hA3) begin n_fail++; $display("FAIL uart_bytes got %0d frames want 55 A3", uart_q.size() - u0); end
    n_checks++; if (frame_err !== fe0) begin n_fail++; $display("FAIL uart_frame got %0d errors want 0", frame_err - fe0); end
    n_checks++; if (tog_q.size() < u0 + 2 || tog_q[u0] !== 0 || tog_q[u0 + 1] !== 0) begin n_fail++; $display("FAIL uart_sclk_quiet got %0d frames want 0 toggles", tog_q.size() - u0); end
    bad = 0;
    for (int k = 1; k < 10; k++)
      if (edge_q.size() <= e0 + k || edge_q[e0 + k] - edge_q[e0] !== BD * k) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL uart_bit_time got %0d bad edges want 0", bad); end
    n_checks++; if (edge_q.size() <= e0 + 10 || edge_q[e0 + 10] - edge_q[e0] !== 194) begin n_fail++; $display("FAIL uart_gap got %0d edges want start spacing 194", edge_q.size() - e0); end
    n_checks++; if (fl_rise !== 72) begin n_fail++; $display("FAIL uart_rises got %0d want 72", fl_rise); end
  endtask

  task automatic test_midrun_reset;
    logic ok;
    int e0, u0, t0;
    e0 = edge_q.size(); u0 = uart_q.size(); t0 = fl_txn;
    start_boot(64'h025502A3_00000000, 5, 8'h00);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clock);
      if (edge_q.size() >= e0 + 11) ok = 1'b1;
    end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_second_start got %b want 1", ok); end
    repeat (40) @(negedge clock);
    #2 resetb = 1'b0;
    #1;
    n_checks++; if ({mprj_io[6], flash_csb, flash_clk, gpio} !== 4'b1100) begin n_fail++; $display("FAIL mid_async got %b want 1100", {mprj_io[6], flash_csb, flash_clk, gpio}); end
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    wait_halt(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_halt got %b want 1", ok); end
    n_checks++; if (uart_q.size() < u0 + 3 || uart_q[u0 + 1] !== 8'h55 || uart_q[u0 + 2] !== 8'hA3) begin n_fail++; $display("FAIL mid_retx got %0d frames want 3 ending 55 A3", uart_q.size() - u0); end
`ifdef FLASH_WAKEUP_EN
    n_checks++; if (fl_txn - t0 !== 4) begin n_fail++; $display("FAIL mid_txns got %0d want 4", fl_txn - t0); end
`else
    n_checks++; if (fl_txn - t0 !== 2) begin n_fail++; $display("FAIL mid_txns got %0d want 2", fl_txn - t0); end
`endif
  endtask

  task automatic test_power_drop;
    logic ok;
    int t0;
    start_boot(64'h011234_0000000000, 3, 8'h7F);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clock);
      if (mprj_io[31:16] === 16'h1234) ok = 1'b1;
    end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL pg_check_set got %b want 1", ok); end
    repeat (10) @(negedge clock);
    vccd = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++; if ({flash_csb, flash_clk, mprj_io[6], gpio} !== 4'b1010) begin n_fail++; $display("FAIL pg_abort got %b want 1010", {flash_csb, flash_clk, mprj_io[6], gpio}); end
    n_checks++; if (mprj_io[31:16] !== 16'h1234) begin n_fail++; $display("FAIL pg_retain got %h want 1234", mprj_io[31:16]); end
    t0 = fl_txn;
    vccd = 1'b1;
    wait_halt(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL pg_halt got %b want 1", ok); end
`ifdef FLASH_WAKEUP_EN
    n_checks++; if (fl_txn - t0 !== 2) begin n_fail++; $display("FAIL pg_reread got %0d want 2", fl_txn - t0); end
`else
    n_checks++; if (fl_txn - t0 !== 1) begin n_fail++; $display("FAIL pg_reread got %0d want 1", fl_txn - t0); end
`endif
    n_checks++; if (fl_rise !== 96) begin n_fail++; $display("FAIL pg_force_rises got %0d want 96", fl_rise); end
  endtask

  task automatic test_force_halt;
    logic ok;
    int u0;
    start_boot(64'h0, 0, 8'h7F);
    wait_halt(ok);
    n_checks++; if (ok !== 1'b1 || fl_rise !== 96) begin n_fail++; $display("FAIL fh_nops got halt %b rises %0d want 1 96", ok, fl_rise); end
    start_boot(64'h7F7F7F7F_7F7F0112, 8, 8'h34);
    wait_halt(ok);
    n_checks++; if (ok !== 1'b1 || fl_rise !== 88) begin n_fail++; $display("FAIL fh_op01 got halt %b rises %0d want 1 88", ok, fl_rise); end
    n_checks++; if (mprj_io[31:16] !== 16'h0000) begin n_fail++; $display("FAIL fh_op01_noexec got %h want 0000", mprj_io[31:16]); end
    u0 = uart_q.size();
    start_boot(64'h7F7F7F7F_7F7F7F02, 8, 8'h55);
    wait_halt(ok);
    repeat (200) @(negedge clock);
    n_checks++; if (ok !== 1'b1 || fl_rise !== 96) begin n_fail++; $display("FAIL fh_op02 got halt %b rises %0d want 1 96", ok, fl_rise); end
    n_checks++; if (uart_q.size() !== u0 || mprj_io[6] !== 1'b1) begin n_fail++; $display("FAIL fh_op02_notx got %0d frames want 0", uart_q.size() - u0); end
  endtask

  initial begin
    test_reset;
    test_read_framing;
    test_opcode_decode;
    test_uart;
    test_midrun_reset;
    test_power_drop;
    test_force_halt;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
